// File: rtl/drac_pkg.sv
// Shared types for the reduced in-order pipeline: register index, operand bus,
// and the ID->RR and RR->EXE instruction records.
// Ports: none (package).
package drac_pkg;

   localparam int NUM_REGS = 32;
   localparam int XLEN     = 64;
   localparam int REG_W    = $clog2(NUM_REGS);

   typedef logic [REG_W-1:0] reg_t;
   typedef logic [XLEN-1:0]  bus64_t;

   localparam reg_t X0 = '0;

   typedef enum logic [2:0] {
      UNIT_ALU    = 3'd0,
      UNIT_MUL    = 3'd1,
      UNIT_DIV    = 3'd2,
      UNIT_BRANCH = 3'd3,
      UNIT_MEM    = 3'd4
   } functional_unit_t;

   typedef enum logic [5:0] {
      I_ADD = 6'd0,
      I_SUB = 6'd1,
      I_MUL = 6'd2,
      I_AND = 6'd3
   } instr_type_t;

   typedef struct packed {
      logic             valid;
      reg_t             rs1;
      reg_t             rs2;
      reg_t             rd;
      logic             regfile_we;
      functional_unit_t unit;
      instr_type_t      instr_type;
      bus64_t           imm;
      bus64_t           pc;
      logic             use_imm;
   } id_rr_instr_t;

   typedef struct packed {
      id_rr_instr_t instr;
      bus64_t       data_rs1;
      bus64_t       data_rs2;
      logic         rdy1;
      logic         rdy2;
   } rr_exe_instr_t;

   function automatic logic is_x0(input reg_t r);
      return r == X0;
   endfunction

endpackage

// File: rtl/rr_regfile_red.sv
// Integer register file: 32x64, two combinational read ports, one write port, x0 reads 0.
// Latency: reads are combinational; writes visible the cycle after the write edge
//          (same cycle when RR_WB_BYPASS_EN is defined). No backpressure.
// Ports: raddr1_i/raddr2_i -> rdata1_o/rdata2_o; we_i/waddr_i/wdata_i write port.
module rr_regfile_red
   import drac_pkg::*;
(
   input  logic   clk_i,
   input  logic   rstn_i,
   input  reg_t   raddr1_i,
   input  reg_t   raddr2_i,
   output bus64_t rdata1_o,
   output bus64_t rdata2_o,
   input  logic   we_i,
   input  reg_t   waddr_i,
   input  bus64_t wdata_i
);

   bus64_t regs_q [NUM_REGS];
   logic   wr_en;

   // x0 is never written, so its storage stays at its reset value of zero.
   assign wr_en = we_i && !is_x0(waddr_i);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = is_x0(raddr1_i) ? '0 : regs_q[raddr1_i];
      rdata2_o = is_x0(raddr2_i) ? '0 : regs_q[raddr2_i];
`ifdef RR_WB_BYPASS_EN
      // wr_en already excludes x0, so x0 can never be bypassed.
      if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
      if (wr_en && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
   end

endmodule

// File: rtl/rr_stage_red.sv
// Register-read stage: holds one decoded instruction, reads operands, tracks busy destinations.
// Latency: 1 cycle ID->EXE when operands are ready; 1 instruction/cycle sustained.
// Backpressure: stall_o holds ID whenever the held instruction does not fire this cycle.
// Option: RR_WB_BYPASS_EN forwards the write-back port straight to operands and readiness.
// Ports: clk_i, rstn_i, kill_i, stall_i, from_id_i, wb_we_i/wb_rd_i/wb_data_i, to_exe_o, stall_o.
module rr_stage_red
   import drac_pkg::*;
(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          kill_i,
   input  logic          stall_i,
   input  id_rr_instr_t  from_id_i,
   input  logic          wb_we_i,
   input  reg_t          wb_rd_i,
   input  bus64_t        wb_data_i,
   output rr_exe_instr_t to_exe_o,
   output logic          stall_o
);

   id_rr_instr_t        hold_q, hold_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   bus64_t              rdata1, rdata2;
   logic                wb_wr;
   logic                bypass1, bypass2;
   logic                rdy1, rdy2;
   logic                fire;

   assign wb_wr = wb_we_i && !is_x0(wb_rd_i);

   rr_regfile_red u_regfile (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .raddr1_i (hold_q.rs1),
      .raddr2_i (hold_q.rs2),
      .rdata1_o (rdata1),
      .rdata2_o (rdata2),
      .we_i     (wb_we_i),
      .waddr_i  (wb_rd_i),
      .wdata_i  (wb_data_i)
   );

`ifdef RR_WB_BYPASS_EN
   assign bypass1 = wb_wr && (wb_rd_i == hold_q.rs1);
   assign bypass2 = wb_wr && (wb_rd_i == hold_q.rs2);
`else
   assign bypass1 = 1'b0;
   assign bypass2 = 1'b0;
`endif

   assign rdy1 = is_x0(hold_q.rs1) || !busy_q[hold_q.rs1] || bypass1;
   // An immediate-form instruction never waits on rs2.
   assign rdy2 = hold_q.use_imm || is_x0(hold_q.rs2) || !busy_q[hold_q.rs2] || bypass2;

   assign fire    = hold_q.valid && rdy1 && rdy2 && !stall_i;
   assign stall_o = hold_q.valid && !fire;

   always_comb begin
      busy_d = busy_q;
      if (wb_wr) busy_d[wb_rd_i] = 1'b0;
      // Applied after the clear: a newly issued producer is younger than the write-back.
      if (fire && hold_q.regfile_we && !is_x0(hold_q.rd)) busy_d[hold_q.rd] = 1'b1;
      if (kill_i) busy_d = '0;
   end

   always_comb begin
      hold_d = hold_q;
      if (kill_i) begin
         hold_d.valid = 1'b0;
      end else if (!hold_q.valid || fire) begin
         hold_d = from_id_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         hold_q <= '0;
         busy_q <= '0;
      end else begin
         hold_q <= hold_d;
         busy_q <= busy_d;
      end
   end

   // Readiness flags are qualified by hold valid so an empty stage drives all zeros.
   always_comb begin
      to_exe_o             = '0;
      to_exe_o.instr       = hold_q;
      to_exe_o.instr.valid = hold_q.valid && rdy1 && rdy2 && !kill_i;
      to_exe_o.data_rs1    = rdata1;
      to_exe_o.data_rs2    = rdata2;
      to_exe_o.rdy1        = hold_q.valid && rdy1;
      to_exe_o.rdy2        = hold_q.valid && rdy2;
   end

endmodule

// File: tb/tb_rr_stage_red.sv
module tb_rr_stage_red;
   import drac_pkg::*;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          kill = 1'b0;
   logic          stall = 1'b0;
   id_rr_instr_t  from_id = '0;
   logic          wb_we = 1'b0;
   reg_t          wb_rd = '0;
   bus64_t        wb_data = '0;
   rr_exe_instr_t to_exe;
   logic          stall_o;

   always #5 clk = ~clk;

   rr_stage_red dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .kill_i    (kill),
      .stall_i   (stall),
      .from_id_i (from_id),
      .wb_we_i   (wb_we),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .to_exe_o  (to_exe),
      .stall_o   (stall_o)
   );

`ifdef RR_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Architectural model: register values, pending producers, the instruction held in RR.
   bus64_t       m_regs [NUM_REGS];
   bit           m_busy [NUM_REGS];
   id_rr_instr_t sb [$];

   typedef struct {
      int rd;
      int due;
   } wb_job_t;
   wb_job_t wbq [$];

   int           cyc = 0;
   bit           id_taken = 1'b1;
   bit           exec_en = 1'b0;
   id_rr_instr_t cur = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_REGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      sb.delete();
      wbq.delete();
   endtask

   function automatic id_rr_instr_t mk(input int rs1, input int rs2, input int rd,
                                       input bit we, input bit use_imm, input instr_type_t t);
      id_rr_instr_t i;
      i            = '0;
      i.valid      = 1'b1;
      i.rs1        = reg_t'(rs1);
      i.rs2        = reg_t'(rs2);
      i.rd         = reg_t'(rd);
      i.regfile_we = we;
      i.use_imm    = use_imm;
      i.instr_type = t;
      i.unit       = (t == I_MUL) ? UNIT_MUL : UNIT_ALU;
      i.imm        = {$urandom, $urandom};
      i.pc         = {32'h0, $urandom};
      return i;
   endfunction

   // Evaluate the spec rules against the current inputs, then advance the model over the edge.
   task automatic model_step();
      id_rr_instr_t h;
      bit           have, b1, b2, r1, r2, fire, exp_v;
      bus64_t       d1, d2;
      wb_job_t      j;
      have = sb.size() > 0;
      h    = have ? sb[0] : '0;
      b1   = BYP && wb_we && (wb_rd != 0) && (wb_rd == h.rs1);
      b2   = BYP && wb_we && (wb_rd != 0) && (wb_rd == h.rs2);
      r1   = (h.rs1 == 0) || !m_busy[h.rs1] || b1;
      r2   = h.use_imm || (h.rs2 == 0) || !m_busy[h.rs2] || b2;
      fire = have && r1 && r2 && !stall;
      exp_v = have && r1 && r2 && !kill;
      check("out_valid", 64'(to_exe.instr.valid), 64'(exp_v));
      check("stall_o", 64'(stall_o), 64'(have && !fire));
      if (have) begin
         check("rdy1", 64'(to_exe.rdy1), 64'(r1));
         check("rdy2", 64'(to_exe.rdy2), 64'(r2));
      end
      if (exp_v && to_exe.instr.valid) begin
         d1 = b1 ? wb_data : m_regs[h.rs1];
         d2 = b2 ? wb_data : m_regs[h.rs2];
         check("data_rs1", to_exe.data_rs1, d1);
         check("data_rs2", to_exe.data_rs2, d2);
         check("instr_pc", to_exe.instr.pc, h.pc);
         check("instr_imm", to_exe.instr.imm, h.imm);
         check("instr_fields",
               64'({to_exe.instr.rs1, to_exe.instr.rs2, to_exe.instr.rd, to_exe.instr.regfile_we,
                    to_exe.instr.use_imm, to_exe.instr.unit, to_exe.instr.instr_type}),
               64'({h.rs1, h.rs2, h.rd, h.regfile_we, h.use_imm, h.unit, h.instr_type}));
      end
      if (fire && !kill) begin
         void'(sb.pop_front());
         if (exec_en && h.regfile_we && h.rd != 0) begin
            j.rd  = int'(h.rd);
            j.due = cyc + 1 + int'($urandom_range(0, 3));
            wbq.push_back(j);
         end
      end
      if (wb_we && wb_rd != 0) begin
         m_regs[wb_rd] = wb_data;
         m_busy[wb_rd] = 1'b0;
      end
      if (fire && !kill && h.regfile_we && h.rd != 0) m_busy[h.rd] = 1'b1;
      id_taken = kill || !have || fire;
      if (kill) begin
         for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
         sb.delete();
      end else if ((!have || fire) && from_id.valid) begin
         sb.push_back(from_id);
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         check("reset_to_exe_zero", 64'(to_exe == '0), 64'd1);
         check("reset_stall_o", 64'(stall_o), 64'd0);
      end else begin
         model_step();
      end
   end

   task automatic step(input id_rr_instr_t id, input bit we, input int rd, input bus64_t d,
                       input bit st, input bit kl);
      @(posedge clk);
      #1;
      from_id = id;
      wb_we   = we;
      wb_rd   = reg_t'(rd);
      wb_data = d;
      stall   = st;
      kill    = kl;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      clear_model();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Reset and first reads: ADD x5 <- x0,x0
      step(mk(0, 0, 5, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(1);
      // Write-back then read
      step('0, 1'b1, 3, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
      step(mk(3, 0, 0, 1'b0, 1'b1, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(1);
      // RAW hazard: ADD x7, then SUB reading x7, write-back x7 two cycles later
      step(mk(1, 2, 7, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      step(mk(7, 0, 8, 1'b1, 1'b0, I_SUB), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(2);
      step('0, 1'b1, 7, 64'h42, 1'b0, 1'b0);
      idle(2);
      // Execute stall during MUL
      step(mk(3, 4, 10, 1'b1, 1'b0, I_MUL), 1'b0, 0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step('0, 1'b0, 0, '0, 1'b1, 1'b0);
      idle(2);
      // Kill with held instruction, busy x9 and a simultaneous write-back x4
      step(mk(0, 0, 9, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      step(mk(9, 0, 12, 1'b1, 1'b0, I_SUB), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(1);
      step('0, 1'b1, 4, 64'hFF, 1'b0, 1'b1);
      idle(1);
      step(mk(4, 9, 0, 1'b0, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(1);
      // x0 rules
      step('0, 1'b1, 0, 64'hDEAD, 1'b0, 1'b0);
      step(mk(0, 0, 0, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      step(mk(0, 0, 13, 1'b0, 1'b0, I_AND), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(2);

      // Randomized traffic with a small executor model writing results back
      exec_en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         bit     we;
         int     rd;
         bus64_t d;
         if (id_taken) begin
            if ($urandom_range(0, 3) != 0)
               cur = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), instr_type_t'($urandom_range(0, 3)));
            else
               cur = '0;
         end
         we = 1'b0;
         rd = 0;
         d  = {$urandom, $urandom};
         if (wbq.size() > 0 && wbq[0].due <= cyc + 1) begin
            we = 1'b1;
            rd = wbq[0].rd;
            void'(wbq.pop_front());
         end else if ($urandom_range(0, 9) == 0) begin
            we = 1'b1;
            rd = int'($urandom_range(0, 7));
         end
         step(cur, we, rd, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
      end
      exec_en = 1'b0;

      // Drain: write every register so no operand stays busy; the held instruction must retire.
      for (int r = 1; r < NUM_REGS; r++) step('0, 1'b1, r, {$urandom, $urandom}, 1'b0, 1'b0);
      idle(3);
      check("drain_empty", 64'(sb.size()), 64'd0);

      // Reset in the middle of operation with a stalled instruction held
      step(mk(3, 0, 11, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b1, 1'b0);
      step('0, 1'b0, 0, '0, 1'b1, 1'b0);
      #2 rstn = 1'b0;
      clear_model();
      id_taken = 1'b1;
      @(posedge clk);
      #1;
      stall = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      step(mk(3, 5, 14, 1'b1, 1'b0, I_ADD), 1'b0, 0, '0, 1'b0, 1'b0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_stage_red.md
# rr_stage_red

Register-read stage of the reduced in-order pipeline, sitting directly upstream of `exe_stage_red`.
- Holds one decoded instruction from ID and reads its two source operands from an internal 32×64 integer register file.
- Tracks in-flight destinations in a busy-bit scoreboard and presents an `rr_exe_instr_t` to execute only once both operands are valid.
- Takes the write-back port and back-pressures ID through `stall_o`.

## Interface
- `NUM_REGS`, 32, architectural integer registers; x0 is hardwired to zero.
- `XLEN`, 64, register and operand width.
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `kill_i` in 1: pipeline flush.
- `stall_i` in 1: execute cannot accept, driven by `exe_cu_o.stall`.
- `from_id_i` in `id_rr_instr_t`: decoded instruction (valid, rs1, rs2, rd, regfile_we, unit, instr_type, imm, pc, use_imm).
- `wb_we_i` in 1: write-back write enable.
- `wb_rd_i` in 5: write-back destination.
- `wb_data_i` in `XLEN`: write-back data.
- `to_exe_o` out `rr_exe_instr_t`: instruction, `data_rs1`, `data_rs2`, `rdy1`, `rdy2`.
- `stall_o` out 1: ID must hold its instruction.

## Operation
- **Holding register `hold`:** loads `from_id_i` on an edge where `!hold.valid || fire`; otherwise it keeps its value.
- **`fire`:** `hold.valid && rdy1 && rdy2 && !stall_i`.
- **Operand ready:** `rdy1` = `rs1==0 || !busy[rs1] || bypass1`; `rdy2` likewise for rs2.
  - `rs2` counts as ready when the instruction does not use it (`use_imm`).
- **Operand data:** `data_rsN` is read combinationally from the register file every cycle using the held indices, so a write-back that arrives while the instruction is held refreshes the operand.
- **Output valid:** `to_exe_o.instr.valid` = `hold.valid && rdy1 && rdy2`. All other `to_exe_o` fields pass through from `hold`.
- **`stall_o`:** `hold.valid && !fire`.
- **Register file:** written on `wb_we_i && wb_rd_i!=0`. Writes to x0 are discarded and x0 always reads 0.
- **Scoreboard:**
  - On `fire` with `regfile_we && rd!=0`, set `busy[rd]`.
  - On a write-back write, clear `busy[wb_rd_i]`.
  - Set and clear of the same register in one cycle: set wins, because the new producer is younger.
- **Kill:**
  - The next edge clears `hold.valid` and all busy bits; kill takes priority over load and `fire`.
  - A write-back write in the same cycle still updates the register file.
  - `to_exe_o.instr.valid` is forced to 0 in the kill cycle.
- **Reset values:** `hold` is all zero, busy bits are 0, the register file is all zero, `to_exe_o` is all zero and `stall_o` is 0.
- **Reset mid-operation:** the held instruction is discarded and the state matches the reset values above.

## Timing
- An instruction presented by ID in cycle N appears valid on `to_exe_o` in cycle N+1, provided its operands are ready.
- With `stall_i=0` the stage sustains one instruction per cycle.
- Back-to-back dependency: the consumer waits until the producer's write-back cycle (with bypass) or the cycle after it (without bypass).
- Execute consumes `to_exe_o` on the edge ending a cycle in which it is valid and `stall_i=0`. `to_exe_o` stays stable while `stall_i=1`.

## Configuration
- `RR_WB_BYPASS_EN` defined:
  - `bypassN` = `wb_we_i && wb_rd_i==rsN && rsN!=0`.
  - `data_rsN` takes `wb_data_i` in that same cycle, and the operand is ready immediately.
- `RR_WB_BYPASS_EN` undefined:
  - `bypassN` = 0.
  - The operand becomes ready and visible one cycle after the write-back.
  - This removes the write-back-to-execute combinational path.

## Structure
- `id_rr_instr_t`, `rr_exe_instr_t` and `reg_t` live in `drac_pkg`, as do the constants `NUM_REGS` and the x0 index.
- One natural sub-module: `rr_regfile_red` (2 read ports, 1 write port, async reset, x0 hardwired, bypass under the macro).
- The scoreboard and holding register stay in `rr_stage_red`.

## Test plan
- **Reset and first reads:** release reset, issue ADD with rs1=x0, rs2=x0, rd=x5.
  - Expect `to_exe_o` valid the next cycle with data 0/0, rdy 1/1, and `busy[5]`=1 after `fire`.
- **Write-back then read:** write-back x3=0x1234_5678_9ABC_DEF0, then issue an instruction with rs1=x3.
  - Expect `data_rs1`=0x1234_5678_9ABC_DEF0.
- **RAW hazard:** fire ADD rd=x7, then SUB rs1=x7.
  - Expect SUB held with valid 0, `stall_o`=1.
  - Write-back x7=0x42.
  - Bypass build: SUB valid that cycle with `data_rs1`=0x42. Non-bypass build: valid one cycle later.
- **Execute stall:** assert `stall_i` for 5 cycles during MUL.
  - Expect `to_exe_o` stable, `stall_o`=1 and no busy bit set.
  - After deassert, exactly one `fire`.
- **Kill:** `kill_i` with a held instruction, `busy[9]`=1 and a simultaneous write-back to x4=0xFF.
  - Next cycle: `hold.valid`=0 and all busy bits 0.
  - Reading x4 returns 0xFF.
- **x0 rules:** write-back to x0=0xDEAD, then issue an instruction with rs1=x0.
  - Expect `data_rs1`=0, rdy1=1, and no busy bit set for rd=0.
